// File: rtl/vector_div4_seq.sv
// rtl/vector_div4_seq.sv - sequential restoring sign-magnitude signed divider with start/busy/done handshake
// Produces {Rem, Q} in the same packed layout as the vector ALU multiply result.
module vector_div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     R,
    input  logic [WIDTH-1:0]     S,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Rem,
    output logic [2*WIDTH-1:0]   Y2,
    output logic                 dz,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   abs_s_q, abs_s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             sign_r_q, sign_r_d;
    logic             sign_s_q, sign_s_d;
    logic             dz_path_q, dz_path_d;
    logic             ovf_path_q, ovf_path_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   r_ext, s_ext;
    logic [WIDTH:0]   abs_r, abs_s;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] a_shift;
    logic             s_is_zero;
    logic             ovf_case;

    // State register and all datapath flops share one synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            a_q        <= '0;
            abs_s_q    <= '0;
            r_q        <= '0;
            sign_r_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            dz_path_q  <= 1'b0;
            ovf_path_q <= 1'b0;
            q_q        <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            a_q        <= a_d;
            abs_s_q    <= abs_s_d;
            r_q        <= r_d;
            sign_r_q   <= sign_r_d;
            sign_s_q   <= sign_s_d;
            dz_path_q  <= dz_path_d;
            ovf_path_q <= ovf_path_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. Divide-by-zero spends a single RUN edge so its done lands two edges after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cnt_q == CW'(1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand conditioning; magnitudes carry one extra bit so |-2^(WIDTH-1)| fits.
    always_comb begin
        r_ext     = {R[WIDTH-1], R};
        s_ext     = {S[WIDTH-1], S};
        abs_r     = R[WIDTH-1] ? (~r_ext + 1'b1) : r_ext;
        abs_s     = S[WIDTH-1] ? (~s_ext + 1'b1) : s_ext;
        s_is_zero = (S == '0);
        ovf_case  = (R == {1'b1, {(WIDTH-1){1'b0}}}) && (S == '1);
        p_shift   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
        a_shift   = {a_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        cnt_d      = cnt_q;
        p_d        = p_q;
        a_d        = a_q;
        abs_s_d    = abs_s_q;
        r_d        = r_q;
        sign_r_d   = sign_r_q;
        sign_s_d   = sign_s_q;
        dz_path_d  = dz_path_q;
        ovf_path_d = ovf_path_q;
        q_d        = q_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_r_d   = R[WIDTH-1];
                    sign_s_d   = S[WIDTH-1];
                    a_d        = abs_r[WIDTH-1:0];
                    abs_s_d    = abs_s;
                    p_d        = '0;
                    r_d        = R;
                    dz_path_d  = s_is_zero;
                    ovf_path_d = ovf_case;
                    cnt_d      = s_is_zero ? CW'(1) : CW'(WIDTH);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!dz_path_q) begin
                    // Unsigned compare stands in for the sign of the WIDTH+1 bit trial subtraction.
                    if (p_shift >= abs_s_q) begin
                        p_d = p_shift - abs_s_q;
                        a_d = {a_shift[WIDTH-1:1], 1'b1};
                    end else begin
                        p_d = p_shift;
                        a_d = a_shift;
                    end
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (dz_path_q) begin
                    q_d   = '1;
                    rem_d = r_q;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else if (ovf_path_q) begin
                    q_d   = {1'b0, {(WIDTH-1){1'b1}}};
                    rem_d = '0;
                    dz_d  = 1'b0;
                    ovf_d = 1'b1;
                end else begin
                    q_d   = (sign_r_q != sign_s_q) ? (~a_q + 1'b1) : a_q;
                    rem_d = sign_r_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        Q    = q_q;
        Rem  = rem_q;
        Y2   = {rem_q, q_q};
        dz   = dz_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_vector_div4_seq.sv
// tb/tb_vector_div4_seq.sv - self-checking bench for vector_div4_seq
module tb_vector_div4_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] R;
    logic [3:0] S;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [3:0] Rem;
    logic [7:0] Y2;
    logic       dz;
    logic       ovf;

    int checks;
    int errors;

    vector_div4_seq #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .R     (R),
        .S     (S),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .Rem   (Rem),
        .Y2    (Y2),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] s;
        logic [3:0] q;
        logic [3:0] rem;
        logic       dzf;
        logic       ovff;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero and % follows the dividend sign.
    task automatic model(input logic [3:0] r, input logic [3:0] s,
                         output logic [3:0] q, output logic [3:0] rem,
                         output logic dzf, output logic ovff, output int lat);
        int ri;
        int si;
        ri = $signed(r);
        si = $signed(s);
        dzf = 1'b0;
        ovff = 1'b0;
        lat = 5;
        if (si == 0) begin
            q = 4'hF;
            rem = r;
            dzf = 1'b1;
            lat = 2;
        end else if (ri == -8 && si == -1) begin
            q = 4'd7;
            rem = 4'd0;
            ovff = 1'b1;
        end else begin
            q = 4'(ri / si);
            rem = 4'(ri % si);
        end
    endtask

    // Waits for done after the accepting edge; lat_out is edges counted, 99 on timeout.
    task automatic wait_done(output int lat_out);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat_out = done ? n : 99;
    endtask

    task automatic launch(input logic [3:0] r, input logic [3:0] s);
        R = r;
        S = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] r, input logic [3:0] s, input int lat);
        logic [3:0] eq;
        logic [3:0] er;
        logic edz;
        logic eov;
        int elat;
        model(r, s, eq, er, edz, eov, elat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " Q"}, Q, eq);
        chk({tag, " Rem"}, Rem, er);
        chk({tag, " Y2"}, Y2, {er, eq});
        chk({tag, " dz"}, dz, edz);
        chk({tag, " ovf"}, ovf, eov);
    endtask

    vec_t vecs[$];
    int   lat;
    int   busy_cycles;
    logic saw_done;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        R = 4'h0;
        S = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset Y2", Y2, 0);
        chk("reset flags", {dz, ovf}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        vecs.push_back('{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h6, 4'hD, 4'hE, 4'h0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h8, 4'hF, 4'h7, 4'h0, 1'b0, 1'b1, 5});
        vecs.push_back('{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 2});
        vecs.push_back('{4'h3, 4'h3, 4'h1, 4'h0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h8, 4'h3, 4'hE, 4'hE, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h8, 4'h8, 4'h1, 4'h0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 5});

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].r, vecs[i].s);
            wait_done(lat);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d Q", i), Q, vecs[i].q);
            chk($sformatf("vec%0d Rem", i), Rem, vecs[i].rem);
            chk($sformatf("vec%0d Y2", i), Y2, {vecs[i].rem, vecs[i].q});
            chk($sformatf("vec%0d flags", i), {dz, ovf}, {vecs[i].dzf, vecs[i].ovff});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse", i), done, 0);
        end

        // Busy spans exactly five cycles for a normal op.
        R = 4'h7;
        S = 4'h2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
        chk("busy cycles", busy_cycles, 5);

        // dz followed by a normal op clears dz.
        launch(4'h5, 4'h0);
        wait_done(lat);
        chk("dz set", dz, 1);
        launch(4'h7, 4'h2);
        wait_done(lat);
        check_result("dz clear", 4'h7, 4'h2, lat);

        // start while busy is ignored.
        launch(4'h7, 4'h2);
        @(posedge clk);
        #1;
        R = 4'h1;
        S = 4'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("ignore latency", lat, 3);
        chk("ignore Y2", Y2, 8'h13);
        @(posedge clk);
        #1;
        chk("ignore no relaunch", busy, 0);

        // Back-to-back: start held in the done cycle.
        launch(4'h7, 4'h2);
        wait_done(lat);
        check_result("b2b first", 4'h7, 4'h2, lat);
        launch(4'hE, 4'h3);
        chk("b2b done low", done, 0);
        wait_done(lat);
        check_result("b2b second", 4'hE, 4'h3, lat);

        // Reset mid-operation aborts without a done pulse.
        launch(4'h7, 4'h2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort outputs", {done, Y2, dz, ovf}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] rr;
            logic [3:0] ss;
            rr = 4'($urandom_range(0, 15));
            ss = 4'($urandom_range(0, 15));
            if (i % 10 == 0) ss = 4'h0;
            if (i % 13 == 0) begin
                rr = 4'h8;
                ss = 4'hF;
            end
            launch(rr, ss);
            wait_done(lat);
            check_result($sformatf("rand%0d", i), rr, ss, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
